// File: rtl/game_pkg.sv
// Shared game constants and types.
//   - Screen bounds and the play-mode encoding driven by the game-mode controller.
//   - Saucer bonus table, selected by the number of shots fired during a flight.
//   - Saucer life-cycle state type.
package game_pkg;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [1:0]  MODE_PLAY = 2'd2;

  localparam logic [8:0] BONUS_0 = 9'd50;
  localparam logic [8:0] BONUS_1 = 9'd100;
  localparam logic [8:0] BONUS_2 = 9'd150;
  localparam logic [8:0] BONUS_3 = 9'd300;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    WAIT    = 2'd1,
    FLY     = 2'd2,
    EXPLODE = 2'd3
  } saucer_state_t;

  // Bonus awarded for a saucer hit, indexed by the shot counter (mod 4).
  function automatic logic [8:0] bonus_for_shots(input logic [1:0] shots);
    logic [8:0] value;
    case (shots)
      2'd0:    value = BONUS_0;
      2'd1:    value = BONUS_1;
      2'd2:    value = BONUS_2;
      default: value = BONUS_3;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free-running, one step per clock.
//   clk  : system clock
//   rst  : synchronous active-high reset, reloads SEED
//   lfsr : current register value
// SEED must be non-zero, otherwise the sequence locks at zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  // Right-shifting Galois form: the bit shifted out is fed back into the tap mask.
  localparam logic [15:0] TAP_MASK = 16'hB400;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & TAP_MASK);
    end
  end

endmodule

// File: rtl/saucer_sequencer.sv
// Flying-saucer bonus target sequencer: random wait, left-moving flight,
// laser hit detection and explosion hold.
//   clk, rst          : clock, synchronous active-high reset
//   restart, mode     : game restart (level) and game mode; only mode 2 plays
//   frame_tick        : one-cycle pulse per VGA frame, paces all timing
//   laser_active/fire : spaceship laser in flight / fired this cycle
//   laser_x, laser_y  : laser position
//   saucer_x          : saucer x-centre for the renderer
//   saucer_visible    : saucer flying
//   saucer_exploding  : explosion being shown
//   score_pulse       : one-cycle award strobe, score_value valid with it
//   score_value       : bonus points, holds between awards
//   laser_kill        : one-cycle strobe telling the laser logic to consume the shot
module saucer_sequencer
  import game_pkg::*;
#(
  parameter logic [10:0] START_X         = 11'd680,
  parameter logic [10:0] STEP            = 11'd1,
  parameter logic [3:0]  FRAMES_PER_STEP = 4'd3,
  parameter logic [10:0] MIN_WAIT        = 11'd600,
  parameter logic [5:0]  EXPLODE_FRAMES  = 6'd30,
  parameter logic [10:0] HALF_LEN        = 11'd20,
  parameter logic [10:0] SAUCER_TOP      = 11'd50,
  parameter logic [10:0] SAUCER_BOTTOM   = 11'd66,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [1:0]  mode,
  input  logic        frame_tick,
  input  logic        laser_active,
  input  logic        laser_fire,
  input  logic [10:0] laser_x,
  input  logic [10:0] laser_y,
  output logic [10:0] saucer_x,
  output logic        saucer_visible,
  output logic        saucer_exploding,
  output logic        score_pulse,
  output logic [8:0]  score_value,
  output logic        laser_kill
);

  saucer_state_t state_q, state_d;
  logic [10:0]   x_d;
  logic [10:0]   wait_q, wait_d;
  logic [3:0]    div_q, div_d;
  logic [5:0]    exp_q, exp_d;
  logic [1:0]    shot_q, shot_d;
  logic          score_d, kill_d;
  logic [8:0]    value_d;
  logic [15:0]   lfsr_value;
  logic [10:0]   wait_load;
  logic          hit;
  logic          unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr_value)
  );

  assign wait_load      = MIN_WAIT + {2'b00, lfsr_value[8:0]};
  assign unused_lfsr_hi = ^lfsr_value[15:9];

  // Hitbox in 12-bit signed so the left edge may go negative near x=0.
  logic signed [11:0] sx, lx, ly;
  assign sx = $signed({1'b0, saucer_x});
  assign lx = $signed({1'b0, laser_x});
  assign ly = $signed({1'b0, laser_y});

  assign hit = laser_active
            && (ly >= $signed({1'b0, SAUCER_TOP}))
            && (ly <= $signed({1'b0, SAUCER_BOTTOM}))
            && (lx >= sx - $signed({1'b0, HALF_LEN}))
            && (lx <= sx + $signed({1'b0, HALF_LEN}));

  always_comb begin
    state_d = state_q;
    x_d     = saucer_x;
    wait_d  = wait_q;
    div_d   = div_q;
    exp_d   = exp_q;
    shot_d  = shot_q;
    score_d = 1'b0;
    kill_d  = 1'b0;
    value_d = score_value;

    if (restart || (mode != MODE_PLAY)) begin
      state_d = OFF;
      x_d     = START_X;
      wait_d  = '0;
      div_d   = '0;
      exp_d   = '0;
      shot_d  = '0;
      value_d = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = WAIT;
          wait_d  = wait_load;
        end
        WAIT: begin
          if (frame_tick) begin
            if (wait_q == 11'd1) begin
              state_d = FLY;
              x_d     = START_X;
              div_d   = '0;
              shot_d  = '0;
            end else begin
              wait_d = wait_q - 11'd1;
            end
          end
        end
        FLY: begin
          // A hit pre-empts movement, exit and shot counting in the same cycle.
          if (hit) begin
            state_d = EXPLODE;
            exp_d   = '0;
            score_d = 1'b1;
            kill_d  = 1'b1;
            value_d = bonus_for_shots(shot_q);
          end else begin
            if (laser_fire) begin
              shot_d = shot_q + 2'd1;
            end
            if (frame_tick) begin
              if (div_q == FRAMES_PER_STEP - 4'd1) begin
                div_d = '0;
                if (saucer_x < STEP) begin
                  state_d = WAIT;
                  wait_d  = wait_load;
                end else begin
                  x_d = saucer_x - STEP;
                end
              end else begin
                div_d = div_q + 4'd1;
              end
            end
          end
        end
        EXPLODE: begin
          if (frame_tick) begin
            if (exp_q == EXPLODE_FRAMES - 6'd1) begin
              state_d = WAIT;
              wait_d  = wait_load;
            end else begin
              exp_d = exp_q + 6'd1;
            end
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= OFF;
      saucer_x         <= START_X;
      wait_q           <= '0;
      div_q            <= '0;
      exp_q            <= '0;
      shot_q           <= '0;
      score_pulse      <= 1'b0;
      laser_kill       <= 1'b0;
      score_value      <= '0;
      saucer_visible   <= 1'b0;
      saucer_exploding <= 1'b0;
    end else begin
      state_q          <= state_d;
      saucer_x         <= x_d;
      wait_q           <= wait_d;
      div_q            <= div_d;
      exp_q            <= exp_d;
      shot_q           <= shot_d;
      score_pulse      <= score_d;
      laser_kill       <= kill_d;
      score_value      <= value_d;
      saucer_visible   <= (state_d == FLY);
      saucer_exploding <= (state_d == EXPLODE);
    end
  end

endmodule

// File: tb/tb_saucer_sequencer.sv
// Self-checking bench for saucer_sequencer with default parameters.
module tb_saucer_sequencer;

  localparam int          START_X        = 680;
  localparam int          STEP           = 1;
  localparam int          FPS            = 3;
  localparam int          MIN_WAIT       = 600;
  localparam int          EXPLODE_FRAMES = 30;
  localparam int          HALF_LEN       = 20;
  localparam int          TOP            = 50;
  localparam int          BOTTOM         = 66;
  localparam logic [15:0] SEED           = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, restart, frame_tick, laser_active, laser_fire;
  logic [1:0]  mode;
  logic [10:0] laser_x, laser_y;
  logic [10:0] saucer_x;
  logic        saucer_visible, saucer_exploding, score_pulse, laser_kill;
  logic [8:0]  score_value;

  int checks   = 0;
  int failures = 0;

  saucer_sequencer #(
    .START_X        (11'd680),
    .STEP           (11'd1),
    .FRAMES_PER_STEP(4'd3),
    .MIN_WAIT       (11'd600),
    .EXPLODE_FRAMES (6'd30),
    .HALF_LEN       (11'd20),
    .SAUCER_TOP     (11'd50),
    .SAUCER_BOTTOM  (11'd66),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .restart         (restart),
    .mode            (mode),
    .frame_tick      (frame_tick),
    .laser_active    (laser_active),
    .laser_fire      (laser_fire),
    .laser_x         (laser_x),
    .laser_y         (laser_y),
    .saucer_x        (saucer_x),
    .saucer_visible  (saucer_visible),
    .saucer_exploding(saucer_exploding),
    .score_pulse     (score_pulse),
    .score_value     (score_value),
    .laser_kill      (laser_kill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_COUNTDOWN, M_FLIGHT, M_BOOM} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_x = START_X, m_left = 0, m_fly_ticks = 0, m_boom_ticks = 0;
  int          m_shots = 0, m_value = 0;
  bit          m_pulse = 1'b0, m_valid = 1'b0;
  logic [15:0] m_lfsr = SEED;
  int          bonus [4] = '{50, 100, 150, 300};

  function automatic logic [15:0] galois_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic m_countdown(input logic [15:0] l);
    m_phase = M_COUNTDOWN;
    m_left  = MIN_WAIT + int'(l[8:0]);
  endtask

  task automatic m_idle();
    m_phase      = M_IDLE;
    m_x          = START_X;
    m_left       = 0;
    m_fly_ticks  = 0;
    m_boom_ticks = 0;
    m_shots      = 0;
    m_value      = 0;
  endtask

  always @(posedge clk) begin
    logic [15:0] cur;
    bit          in_box;
    cur     = m_lfsr;
    m_pulse = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_lfsr  = SEED;
      m_idle();
    end else begin
      m_lfsr = galois_next(cur);
      if (restart || mode != 2'd2) begin
        m_idle();
      end else begin
        case (m_phase)
          M_IDLE: m_countdown(cur);
          M_COUNTDOWN: if (frame_tick) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = M_FLIGHT; m_x = START_X; m_fly_ticks = 0; m_shots = 0;
            end
          end
          M_FLIGHT: begin
            in_box = laser_active && int'(laser_y) >= TOP && int'(laser_y) <= BOTTOM
                     && int'(laser_x) >= m_x - HALF_LEN && int'(laser_x) <= m_x + HALF_LEN;
            if (in_box) begin
              m_phase = M_BOOM; m_boom_ticks = 0; m_pulse = 1'b1;
              m_value = bonus[m_shots % 4];
            end else begin
              if (laser_fire) m_shots++;
              if (frame_tick) begin
                m_fly_ticks++;
                if (m_fly_ticks % FPS == 0) begin
                  if (m_x < STEP) m_countdown(cur);
                  else m_x = m_x - STEP;
                end
              end
            end
          end
          M_BOOM: if (frame_tick) begin
            m_boom_ticks++;
            if (m_boom_ticks == EXPLODE_FRAMES) m_countdown(cur);
          end
          default: m_idle();
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("saucer_x", 32'(saucer_x), 32'(m_x));
      check("saucer_visible", 32'(saucer_visible), 32'(m_phase == M_FLIGHT));
      check("saucer_exploding", 32'(saucer_exploding), 32'(m_phase == M_BOOM));
      check("score_pulse", 32'(score_pulse), 32'(m_pulse));
      check("laser_kill", 32'(laser_kill), 32'(m_pulse));
      check("score_value", 32'(score_value), 32'(m_value));
      check("lfsr", 32'(dut.lfsr_value), 32'(m_lfsr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_frame();
    frame_tick = 1'b1;
    @(posedge clk); #2;
    frame_tick = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic shoot(input int x, input int y);
    laser_active = 1'b1; laser_x = 11'(x); laser_y = 11'(y);
    @(posedge clk); #2;
    laser_active = 1'b0;
  endtask

  task automatic fire();
    laser_fire = 1'b1;
    @(posedge clk); #2;
    laser_fire = 1'b0;
  endtask

  task automatic to_flight(output int n);
    n = 0;
    while (!saucer_visible && n < 1200) begin tick_frame(); n++; end
    check("wait_within_bound", 32'(n < 1200), 32'd1);
  endtask

  task automatic ride_explosion(output int n);
    n = 0;
    while (saucer_exploding && n < 100) begin tick_frame(); n++; end
  endtask

  initial begin
    int n;
    rst = 1'b1; restart = 1'b0; mode = 2'd2; frame_tick = 1'b0;
    laser_active = 1'b0; laser_fire = 1'b0; laser_x = '0; laser_y = '0;
    repeat (3) @(posedge clk); #2;
    check("rst_x", 32'(saucer_x), 32'd680);
    check("rst_visible", 32'(saucer_visible), 32'd0);
    check("rst_value", 32'(score_value), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_value), 32'hACE1);
    rst = 1'b0;
    @(posedge clk); #2;
    check("lfsr_step1", 32'(dut.lfsr_value), 32'hE270);

    // seed low bits 0x0E1 = 225 -> first wait 825 ticks
    to_flight(n);
    check("first_wait_ticks", 32'(n), 32'd825);
    repeat (2) tick_frame();
    check("x_after_2", 32'(saucer_x), 32'd680);
    tick_frame();
    check("x_after_3", 32'(saucer_x), 32'd679);
    n = 3;
    while (saucer_visible && n < 3000) begin tick_frame(); n++; end
    check("flight_ticks", 32'(n), 32'd2043);
    check("exit_x_zero", 32'(saucer_x), 32'd0);

    // hitbox edges at x=300
    to_flight(n);
    check("wait_ge_min", 32'(n >= MIN_WAIT), 32'd1);
    repeat (1140) tick_frame();
    check("x_300", 32'(saucer_x), 32'd300);
    shoot(321, 60);
    check("miss_right_pulse", 32'(score_pulse), 32'd0);
    shoot(320, 67);
    check("miss_below_pulse", 32'(score_pulse), 32'd0);
    shoot(315, 60);
    check("hit_exploding", 32'(saucer_exploding), 32'd1);
    check("hit_pulse", 32'(score_pulse), 32'd1);
    check("hit_kill", 32'(laser_kill), 32'd1);
    check("hit_value_50", 32'(score_value), 32'd50);
    @(posedge clk); #2;
    check("pulse_one_cycle", 32'(score_pulse), 32'd0);
    check("value_holds", 32'(score_value), 32'd50);

    ride_explosion(n);
    check("explode_ticks", 32'(n), 32'd30);
    to_flight(n);
    check("wait_ge_min2", 32'(n >= MIN_WAIT), 32'd1);

    repeat (3) fire();
    laser_fire = 1'b1;  // same-cycle fire is ignored by the hit
    shoot(680, 50);
    laser_fire = 1'b0;
    check("three_shots_300", 32'(score_value), 32'd300);
    ride_explosion(n);
    to_flight(n);
    repeat (5) fire();
    shoot(660, 66);
    check("five_shots_100", 32'(score_value), 32'd100);
    ride_explosion(n);
    to_flight(n);

    // hit on the exit-step tick at x=0
    repeat (2042) tick_frame();
    check("x_zero_before_exit", 32'(saucer_x), 32'd0);
    frame_tick = 1'b1; laser_fire = 1'b1;
    shoot(5, 60);
    frame_tick = 1'b0; laser_fire = 1'b0;
    check("edge_hit_exploding", 32'(saucer_exploding), 32'd1);
    check("edge_hit_pulse", 32'(score_pulse), 32'd1);
    check("edge_hit_value", 32'(score_value), 32'd50);
    ride_explosion(n);
    to_flight(n);

    // restart mid-flight
    repeat (4) tick_frame();
    restart = 1'b1;
    @(posedge clk); #2;
    restart = 1'b0;
    check("restart_visible", 32'(saucer_visible), 32'd0);
    check("restart_x", 32'(saucer_x), 32'd680);
    @(posedge clk); #2;
    to_flight(n);

    // mode drop on a would-be hit cycle suppresses the pulse
    mode = 2'd1;
    shoot(680, 60);
    check("mode_off_pulse", 32'(score_pulse), 32'd0);
    check("mode_off_kill", 32'(laser_kill), 32'd0);
    check("mode_off_exploding", 32'(saucer_exploding), 32'd0);
    mode = 2'd2;
    @(posedge clk); #2;
    to_flight(n);

    shoot(690, 55);
    check("hit_again", 32'(saucer_exploding), 32'd1);
    repeat (3) tick_frame();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_mid_explode_lfsr", 32'(dut.lfsr_value), 32'hACE1);
    check("rst_mid_explode_x", 32'(saucer_x), 32'd680);
    @(posedge clk); #2;
    to_flight(n);
    check("reseeded_wait", 32'(n), 32'd825);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/saucer_sequencer.md
Name: saucer_sequencer

Overview:
Frame-driven controller that sequences the flying-saucer bonus target through its life cycle: randomised wait, left-moving flight, hit detection against the spaceship laser, and explosion hold. It owns the saucer position and visibility flags consumed by the saucer renderer. It also issues one-cycle score and laser-kill pulses to the scoreboard and spaceship laser logic. It sits between the VGA timing (frame tick), the game-mode controller, and the saucer draw logic.

Parameters:
START_X, 11'd680, spawn x-centre (off-screen right)
STEP, 11'd1, pixels moved per step
FRAMES_PER_STEP, 4'd3, frame ticks per step
MIN_WAIT, 11'd600, minimum wait in frame ticks
EXPLODE_FRAMES, 6'd30, explosion hold in frame ticks
HALF_LEN, 11'd20, saucer half-width
SAUCER_TOP, 11'd50, hitbox top row
SAUCER_BOTTOM, 11'd66, hitbox bottom row
LFSR_SEED, 16'hACE1, reset seed (must be non-zero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
restart  in  1  game restart, synchronous, level
mode  in  2  game mode; play mode == 2
frame_tick  in  1  one-cycle pulse per VGA frame
laser_active  in  1  spaceship laser in flight
laser_fire  in  1  one-cycle pulse when player fires
laser_x  in  11  laser x
laser_y  in  11  laser y
saucer_x  out  11  saucer x-centre
saucer_visible  out  1  state FLY
saucer_exploding  out  1  state EXPLODE
score_pulse  out  1  one-cycle award strobe
score_value  out  9  bonus points, valid with score_pulse
laser_kill  out  1  one-cycle laser-consume strobe

Behaviour:
- Reset (rst, or restart, or mode != 2): state OFF, saucer_x=START_X, all counters 0, all pulses 0. rst also reloads LFSR=LFSR_SEED. restart/mode do not touch the LFSR. Priority: rst > restart > mode.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk, including in OFF.
- States OFF, WAIT, FLY, EXPLODE. All outputs registered.
- OFF -> WAIT on the first clk with mode == 2 and no restart. Entry to WAIT loads wait_cnt = MIN_WAIT + lfsr[8:0] (11-bit, no overflow for defaults).
- WAIT: each frame_tick decrements wait_cnt. A frame_tick with wait_cnt == 1 moves to FLY next cycle with saucer_x=START_X, div=0, shot_cnt=0.
- FLY, movement on each frame_tick:
  - If div == FRAMES_PER_STEP-1: div=0 and take a step.
  - Step: if saucer_x < STEP, go to WAIT (reload wait_cnt); else saucer_x -= STEP. No wrap below 0.
  - Otherwise div += 1.
- FLY, shot count: each laser_fire increments 2-bit shot_cnt (wraps mod 4).
- FLY, hit check every clk, not only on frame_tick. Hit condition:
  - laser_active, and
  - SAUCER_TOP <= laser_y <= SAUCER_BOTTOM, and
  - saucer_x - HALF_LEN <= laser_x <= saucer_x + HALF_LEN.
  - Compare in 12-bit signed arithmetic so saucer_x < HALF_LEN does not wrap.
- On hit, the next cycle:
  - state EXPLODE, exp_cnt=0, saucer_x frozen.
  - score_pulse=1 and laser_kill=1 for exactly one cycle.
  - score_value from shot_cnt (value before any same-cycle laser_fire): 0->50, 1->100, 2->150, 3->300.
- Simultaneous events:
  - Hit beats exit-step and frame_tick in the same cycle.
  - laser_fire in the same cycle as a hit is ignored.
- EXPLODE: each frame_tick increments exp_cnt. At exp_cnt == EXPLODE_FRAMES-1 with a frame_tick, go to WAIT (reload wait_cnt). No hit checks in EXPLODE.
- score_value holds its last value between pulses; it is 0 after reset.
- Reset mid-FLY/EXPLODE: a pulse pending that cycle is suppressed.

Decomposition:
- Shared package game_pkg: screen bounds (640x480), play-mode encoding (2'd2), bonus table constants (50/100/150/300), and the state enum {OFF, WAIT, FLY, EXPLODE}.
- One sub-module, lfsr16 (clk, rst, seed parameter, 16-bit out), is reusable for alien fire timing.
- Hit comparator stays inline.

Test Plan:
1. Small params (START_X=10, FRAMES_PER_STEP=2, MIN_WAIT=4, LFSR_SEED chosen so lfsr[8:0]=0 at WAIT entry), mode=2 after rst -> FLY after 4 frame_ticks; saucer_x=9 after 2 more ticks; WAIT after 22 ticks of flight; saucer_x never below 0.
2. FLY at saucer_x=300; laser_active, laser_x=315, laser_y=60 -> next cycle: EXPLODE, score_pulse and laser_kill high for 1 cycle, score_value=50. With laser_x=321 -> no hit.
3. Three laser_fire pulses, then a hit -> score_value=300. Five pulses, then a hit -> 100.
4. Hit on the same cycle as the exit step (saucer_x=0, laser_x=5) -> EXPLODE, not WAIT; score_pulse once.
5. EXPLODE_FRAMES=30 -> saucer_exploding for exactly 30 frame_ticks, then WAIT with a new wait_cnt >= MIN_WAIT.
6. restart, or mode=1, asserted mid-FLY -> next cycle: OFF, saucer_x=680, no pulses. rst mid-EXPLODE -> LFSR back to 16'hACE1.
